// File: rtl/drac_pkg.sv
// Shared execute-stage types: divider FSM states and the request/response
// structs the instruction-level wrapper maps onto the divider ports.
package drac_pkg;

    localparam int DIV_MAX_BPC = 4;
    localparam int DIV_XLEN    = 64;
    localparam int DIV_TAG_W   = 8;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_ITER,
        DIV_FIXUP,
        DIV_DONE
    } div_state_t;

    typedef struct packed {
        logic [DIV_XLEN-1:0]  dividend;
        logic [DIV_XLEN-1:0]  divisor;
        logic                 is_signed;
        logic                 op_32;
        logic                 rem;
        logic [DIV_TAG_W-1:0] tag;
    } div_req_t;

    typedef struct packed {
        logic [DIV_XLEN-1:0]  result;
        logic [DIV_TAG_W-1:0] tag;
        logic                 div_zero;
    } div_resp_t;

endpackage

// File: rtl/div_step_radix.sv
// Combinational slice of BPC restoring shift-subtract steps on unsigned
// magnitudes; the quotient register shifts dividend bits out and quotient bits in.
module div_step_radix
    import drac_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int BPC  = 2
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quot_next
);

    logic [XLEN-1:0] rem_chain  [0:BPC];
    logic [XLEN-1:0] quot_chain [0:BPC];

    assign rem_chain[0]  = rem;
    assign quot_chain[0] = quot;

    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_step
            logic [XLEN:0] shifted;
            logic [XLEN:0] diff;

            // Borrow out of the extended subtraction means the trial subtract fails.
            assign shifted = {rem_chain[gi], quot_chain[gi][XLEN-1]};
            assign diff    = shifted - {1'b0, divisor};
            assign rem_chain[gi+1]  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            assign quot_chain[gi+1] = {quot_chain[gi][XLEN-2:0], ~diff[XLEN]};
        end
    endgenerate

    assign rem_next  = rem_chain[BPC];
    assign quot_next = quot_chain[BPC];

endmodule

// File: rtl/div_iter_unit.sv
// Iterative radix-2^BITS_PER_CYCLE integer divider, one op in flight.
// Define DIV_ITER_FAST_PATH_EN to retire trivial divisions in a single cycle.
module div_iter_unit
    import drac_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int BITS_PER_CYCLE = 2,
    parameter int TAG_W          = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             kill_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [XLEN-1:0]  dividend_i,
    input  logic [XLEN-1:0]  divisor_i,
    input  logic             signed_i,
    input  logic             op_32_i,
    input  logic             rem_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             div_zero_o
);

    localparam int HALF  = XLEN / 2;
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] N_FULL  = CNT_W'(XLEN / BITS_PER_CYCLE);
    localparam logic [CNT_W-1:0] N_HALF  = CNT_W'(HALF / BITS_PER_CYCLE);
    localparam logic [XLEN-1:0]  LO_MASK = XLEN'(64'h0000_0000_FFFF_FFFF);

    div_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN-1:0]  rem_reg;
    logic [XLEN-1:0]  quot_reg;
    logic [XLEN-1:0]  divisor_reg;
    logic [TAG_W-1:0] tag_reg;
    logic             signed_reg;
    logic             op32_reg;
    logic             rem_sel_reg;
    logic             a_neg_reg;
    logic             q_neg_reg;
    logic             div_zero_reg;
    logic             req_ready_reg;
    logic             resp_valid_reg;
    logic [XLEN-1:0]  result_reg;
    logic [TAG_W-1:0] tag_out_reg;
    logic             div_zero_out_reg;

    logic             a_neg, b_neg, b_zero;
    logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag, quot_init;
    logic [XLEN-1:0]  step_rem, step_quot;
    logic [XLEN-1:0]  q_fix, r_fix, res_raw, res_fix;

    // Operand conditioning for the accept edge: W ops use the low word only.
    always_comb begin
        a_neg     = signed_i & (op_32_i ? dividend_i[31] : dividend_i[XLEN-1]);
        b_neg     = signed_i & (op_32_i ? divisor_i[31] : divisor_i[XLEN-1]);
        a_ext     = op_32_i ? (a_neg ? (dividend_i | ~LO_MASK) : (dividend_i & LO_MASK))
                            : dividend_i;
        b_ext     = op_32_i ? (b_neg ? (divisor_i | ~LO_MASK) : (divisor_i & LO_MASK))
                            : divisor_i;
        a_mag     = a_neg ? -a_ext : a_ext;
        b_mag     = b_neg ? -b_ext : b_ext;
        b_zero    = (b_mag == '0);
        quot_init = op_32_i ? (a_mag << HALF) : a_mag;
    end

`ifdef DIV_ITER_FAST_PATH_EN
    logic fast_small, fast_one;
    assign fast_small = b_zero | (a_mag < b_mag);
    assign fast_one   = (b_mag == XLEN'(1));
`endif

    div_step_radix #(
        .XLEN (XLEN),
        .BPC  (BITS_PER_CYCLE)
    ) u_step (
        .rem       (rem_reg),
        .quot      (quot_reg),
        .divisor   (divisor_reg),
        .rem_next  (step_rem),
        .quot_next (step_quot)
    );

    // MIN / -1 needs no special case: magnitude 2^(XLEN-1) with a positive
    // quotient sign already yields MIN and a zero remainder.
    always_comb begin
        q_fix   = div_zero_reg ? '1 : ((signed_reg & q_neg_reg) ? -quot_reg : quot_reg);
        r_fix   = (signed_reg & a_neg_reg) ? -rem_reg : rem_reg;
        res_raw = rem_sel_reg ? r_fix : q_fix;
        res_fix = op32_reg ? (res_raw[31] ? (res_raw | ~LO_MASK) : (res_raw & LO_MASK))
                           : res_raw;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg        <= DIV_IDLE;
            cnt_reg          <= '0;
            rem_reg          <= '0;
            quot_reg         <= '0;
            divisor_reg      <= '0;
            tag_reg          <= '0;
            signed_reg       <= 1'b0;
            op32_reg         <= 1'b0;
            rem_sel_reg      <= 1'b0;
            a_neg_reg        <= 1'b0;
            q_neg_reg        <= 1'b0;
            div_zero_reg     <= 1'b0;
            req_ready_reg    <= 1'b1;
            resp_valid_reg   <= 1'b0;
            result_reg       <= '0;
            tag_out_reg      <= '0;
            div_zero_out_reg <= 1'b0;
        end else if (kill_i) begin
            state_reg      <= DIV_IDLE;
            resp_valid_reg <= 1'b0;
            req_ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                DIV_IDLE: begin
                    if (req_valid_i && req_ready_reg) begin
                        tag_reg       <= tag_i;
                        signed_reg    <= signed_i;
                        op32_reg      <= op_32_i;
                        rem_sel_reg   <= rem_i;
                        a_neg_reg     <= a_neg;
                        q_neg_reg     <= a_neg ^ b_neg;
                        div_zero_reg  <= b_zero;
                        divisor_reg   <= b_mag;
                        req_ready_reg <= 1'b0;
                        rem_reg       <= '0;
                        quot_reg      <= quot_init;
                        cnt_reg       <= op_32_i ? N_HALF : N_FULL;
                        state_reg     <= DIV_ITER;
`ifdef DIV_ITER_FAST_PATH_EN
                        if (fast_small) begin
                            rem_reg   <= a_mag;
                            quot_reg  <= '0;
                            state_reg <= DIV_FIXUP;
                        end else if (fast_one) begin
                            quot_reg  <= a_mag;
                            state_reg <= DIV_FIXUP;
                        end
`endif
                    end
                end
                DIV_ITER: begin
                    rem_reg  <= step_rem;
                    quot_reg <= step_quot;
                    cnt_reg  <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= DIV_FIXUP;
                    end
                end
                DIV_FIXUP: begin
                    result_reg       <= res_fix;
                    tag_out_reg      <= tag_reg;
                    div_zero_out_reg <= div_zero_reg;
                    resp_valid_reg   <= 1'b1;
                    state_reg        <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (resp_ready_i) begin
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        state_reg      <= DIV_IDLE;
                    end
                end
                default: begin
                    state_reg     <= DIV_IDLE;
                    req_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_reg;
    assign resp_valid_o = resp_valid_reg;
    assign result_o     = result_reg;
    assign tag_o        = tag_out_reg;
    assign div_zero_o   = div_zero_out_reg;

endmodule
